// File: rtl/elastic_async_operator_if.sv
// Handshake bundle for elastic_async_operator: operand join channels on the
// upstream side, result fork channels and FIFO status on the downstream side.
interface elastic_async_operator_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int INPUT_SIZE  = 1,
  parameter int OUTPUT_SIZE = 1,
  parameter int DEPTH       = 2
);
  localparam int LEVEL_W = $clog2(DEPTH + 1);

  logic [INPUT_SIZE-1:0]            req_l;
  logic [INPUT_SIZE-1:0]            ack_l;
  logic [DATA_WIDTH*INPUT_SIZE-1:0] din;
  logic [OUTPUT_SIZE-1:0]           req_r;
  logic [OUTPUT_SIZE-1:0]           ack_r;
  logic [DATA_WIDTH-1:0]            dout;
  logic [LEVEL_W-1:0]               level;

  // Operator side of the bundle.
  modport slave (
    output req_l,
    input  ack_l,
    input  din,
    input  req_r,
    output ack_r,
    output dout,
    output level
  );

  // Environment side: upstream producers and downstream consumers.
  modport master (
    input  req_l,
    output ack_l,
    output din,
    output req_r,
    input  ack_r,
    input  dout,
    input  level
  );
endinterface

// File: rtl/elastic_async_operator.sv
// Dataflow operator node: joins INPUT_SIZE operand channels, applies OP,
// queues results in a DEPTH-entry FIFO and forks the FIFO head to
// OUTPUT_SIZE consumers, each acknowledged independently.
module elastic_async_operator #(
  parameter int    DATA_WIDTH  = 32,
  parameter string OP          = "reg",
  parameter int    IMMEDIATE   = 0,
  parameter int    INPUT_SIZE  = 1,
  parameter int    OUTPUT_SIZE = 1,
  parameter int    DEPTH       = 2
) (
  input logic               clk,
  input logic               rst,
  elastic_async_operator_if.slave bus
);
  localparam int LEVEL_W = $clog2(DEPTH + 1);
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]         LAST_PTR   = AW'(DEPTH - 1);
  localparam logic [LEVEL_W-1:0]    FULL_LEVEL = LEVEL_W'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] IMM        = DATA_WIDTH'(IMMEDIATE);

  logic [DATA_WIDTH-1:0]  r_slot [INPUT_SIZE];
  logic [INPUT_SIZE-1:0]  r_has;
  logic [INPUT_SIZE-1:0]  r_req_l;
  logic [DATA_WIDTH-1:0]  r_fifo [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [LEVEL_W-1:0]     r_level;
  logic [OUTPUT_SIZE-1:0] r_served;
  logic [OUTPUT_SIZE-1:0] r_ack_r;
  logic [DATA_WIDTH-1:0]  r_dout;

  logic [INPUT_SIZE-1:0]  w_capture;
  logic [INPUT_SIZE-1:0]  w_has_next;
  logic                   w_not_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic [OUTPUT_SIZE-1:0] w_serve;
  logic [AW-1:0]          w_wr_ptr_inc;
  logic [AW-1:0]          w_rd_ptr_inc;
  logic [LEVEL_W-1:0]     w_level_next;
  logic [DATA_WIDTH-1:0]  w_dout_next;
  logic [DATA_WIDTH-1:0]  w_result;

  // A slot only accepts data while empty; a late ack on a full slot is dropped.
  assign w_capture    = bus.ack_l & ~r_has;
  assign w_not_empty  = (r_level != {LEVEL_W{1'b0}});
  assign w_full       = (r_level == FULL_LEVEL);
  // Every consumer has taken the head: retire it on this edge.
  assign w_pop        = w_not_empty & (&r_served);
  // Pop on the same edge frees a slot, so a full FIFO can still accept.
  assign w_push       = (&r_has) & (~w_full | w_pop);
  // The r_ack_r term keeps a consumer's ack from being high two cycles running.
  assign w_serve      = {OUTPUT_SIZE{w_not_empty}} & bus.req_r & ~r_served & ~r_ack_r;
  assign w_wr_ptr_inc = (r_wr_ptr == LAST_PTR) ? {AW{1'b0}} : (r_wr_ptr + AW'(1));
  assign w_rd_ptr_inc = (r_rd_ptr == LAST_PTR) ? {AW{1'b0}} : (r_rd_ptr + AW'(1));

  // Operator datapath on the captured operand slots (modulo 2^DATA_WIDTH).
  always_comb begin
    w_result = r_slot[0];
    if (OP == "addi") begin
      w_result = r_slot[0] + IMM;
    end else if (OP == "subi") begin
      w_result = r_slot[0] - IMM;
    end else if (OP == "muli") begin
      w_result = r_slot[0] * IMM;
    end else begin
      for (int i = 1; i < INPUT_SIZE; i++) begin
        if (OP == "add") begin
          w_result = w_result + r_slot[i];
        end else if (OP == "sub") begin
          w_result = w_result - r_slot[i];
        end else if (OP == "mul") begin
          w_result = w_result * r_slot[i];
        end else if (OP == "min") begin
          w_result = (r_slot[i] < w_result) ? r_slot[i] : w_result;
        end else if (OP == "max") begin
          w_result = (r_slot[i] > w_result) ? r_slot[i] : w_result;
        end else begin
          w_result = w_result;
        end
      end
    end
  end

  // Next operand-held flags, FIFO occupancy and head value.
  always_comb begin
    w_has_next   = r_has | w_capture;
    w_level_next = r_level;
    w_dout_next  = r_dout;
    if (w_push) begin
      w_has_next = {INPUT_SIZE{1'b0}};
    end else begin
      w_has_next = r_has | w_capture;
    end
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LEVEL_W'(1);
      2'b01:   w_level_next = r_level - LEVEL_W'(1);
      default: w_level_next = r_level;
    endcase
    if (w_pop) begin
      if (r_level > LEVEL_W'(1)) begin
        w_dout_next = r_fifo[w_rd_ptr_inc];
      end else if (w_push) begin
        w_dout_next = w_result;
      end else begin
        w_dout_next = r_dout;
      end
    end else if (w_push && !w_not_empty) begin
      w_dout_next = w_result;
    end else begin
      w_dout_next = r_dout;
    end
  end

  // Input side: operand capture and per-channel request toward upstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_has   <= {INPUT_SIZE{1'b0}};
      r_req_l <= {INPUT_SIZE{1'b0}};
      for (int i = 0; i < INPUT_SIZE; i++) begin
        r_slot[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      r_has   <= w_has_next;
      r_req_l <= ~w_has_next;
      for (int i = 0; i < INPUT_SIZE; i++) begin
        if (w_capture[i]) begin
          r_slot[i] <= bus.din[DATA_WIDTH*i +: DATA_WIDTH];
        end
      end
    end
  end

  // Result FIFO storage, pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {LEVEL_W{1'b0}};
      r_dout   <= {DATA_WIDTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        r_fifo[k] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      r_level <= w_level_next;
      r_dout  <= w_dout_next;
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_result;
        r_wr_ptr         <= w_wr_ptr_inc;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
    end
  end

  // Output side: one-cycle ack per consumer and served tracking for the head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack_r  <= {OUTPUT_SIZE{1'b0}};
      r_served <= {OUTPUT_SIZE{1'b0}};
    end else begin
      r_ack_r <= w_serve;
      if (w_pop) begin
        r_served <= {OUTPUT_SIZE{1'b0}};
      end else begin
        r_served <= r_served | w_serve;
      end
    end
  end

  assign bus.req_l = r_req_l;
  assign bus.ack_r = r_ack_r;
  assign bus.dout  = r_dout;
  assign bus.level = r_level;
endmodule
